// File: rtl/Full_adder.sv
// One-bit full adder cell; serial_adder drives it one operand bit per clock.
module Full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one Full_adder cell plus a registered carry,
// LSB first, with valid/ready handshakes on operand and result sides.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic             carry;
  logic [CNT_W-1:0] cnt;
  logic             fa_sum;
  logic             fa_cout;

  Full_adder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      sum_sh    <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready comes up one edge after reset release, so that edge never accepts.
          if (!in_ready) begin
            in_ready <= 1'b1;
          end else if (in_valid) begin
            a_sh     <= a;
            b_sh     <= b;
            carry    <= cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_sh <= {fa_sum, sum_sh[WIDTH-1:1]};
          carry  <= fa_cout;
          a_sh   <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh   <= {1'b0, b_sh[WIDTH-1:1]};
          // Hold cnt at LAST rather than wrapping when WIDTH is a power of two.
          if (cnt == LAST) begin
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sum  = sum_sh;
  assign cout = carry;
  assign busy = (state == RUN) || (state == DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed and randomized bench for serial_adder at WIDTH=8 and WIDTH=32.
module tb_serial_adder;

  localparam int W  = 8;
  localparam int W2 = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic          cin = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          in_ready, out_valid, cout, busy;
  logic [W-1:0]  sum;

  logic          in_valid2 = 1'b0;
  logic          out_ready2 = 1'b0;
  logic          cin2 = 1'b0;
  logic [W2-1:0] a2 = '0;
  logic [W2-1:0] b2 = '0;
  logic          in_ready2, out_valid2, cout2, busy2;
  logic [W2-1:0] sum2;

  int n_checks = 0;
  int n_errors = 0;
  int cycle = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder #(.WIDTH(W2)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .cin(cin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .sum(sum2), .cout(cout2), .busy(busy2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One 8-bit operation; out_ready is raised at accept when stall==0,
  // otherwise held low for `stall` cycles after out_valid.
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input int stall, input bit noise, input string tag);
    logic [8:0] exp;
    int cyc;
    exp = {1'b0, ta} + {1'b0, tb} + 9'(tc);
    cyc = 0;
    while (!in_ready && cyc < 50) begin tick(); cyc++; end
    chk({tag, " ready_before"}, 64'(in_ready), 64'd1);
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = (stall == 0);
    chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
    chk({tag, " ready_low_in_run"}, 64'(in_ready), 64'd0);
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      if (noise) begin
        in_valid = 1'($urandom_range(0, 1));
        a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    chk({tag, " latency"}, 64'(cyc), 64'(W));
    chk({tag, " sum"}, 64'({cout, sum}), 64'(exp));
    chk({tag, " no_ready_with_valid"}, 64'(in_ready), 64'd0);
    for (int s = 0; s < stall; s++) begin
      if (noise) in_valid = 1'($urandom_range(0, 1));
      tick();
      chk({tag, " stall_hold"}, 64'({out_valid, busy, cout, sum}), 64'({2'b11, exp}));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " valid_drop"}, 64'(out_valid), 64'd0);
    chk({tag, " ready_back"}, 64'(in_ready), 64'd1);
    chk({tag, " idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run32(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                       input int stall, input string tag);
    logic [32:0] exp;
    int cyc;
    exp = {1'b0, ta} + {1'b0, tb} + 33'(tc);
    cyc = 0;
    while (!in_ready2 && cyc < 100) begin tick(); cyc++; end
    a2 = ta; b2 = tb; cin2 = tc; in_valid2 = 1'b1;
    tick();
    in_valid2 = 1'b0;
    cyc = 0;
    while (!out_valid2 && cyc < 100) begin tick(); cyc++; end
    chk({tag, " latency32"}, 64'(cyc), 64'(W2));
    chk({tag, " sum32"}, 64'({cout2, sum2}), 64'(exp));
    for (int s = 0; s < stall; s++) tick();
    chk({tag, " hold32"}, 64'({out_valid2, cout2, sum2}), 64'({1'b1, exp}));
    out_ready2 = 1'b1;
    tick();
    out_ready2 = 1'b0;
    chk({tag, " drop32"}, 64'({out_valid2, in_ready2}), 64'b01);
  endtask

  initial begin
    int t_acc[4];
    logic [7:0] qa[4];
    logic [7:0] qb[4];
    int cyc;

    // Reset state
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_sum", 64'({cout, sum}), 64'd0);
    in_valid = 1'b1; a = 8'hAA; b = 8'h55;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("first_edge_ready", 64'(in_ready), 64'd1);
    chk("first_edge_no_accept", 64'(busy), 64'd0);
    in_valid = 1'b0;

    // Basic add and carry propagation
    run8(8'h5A, 8'h3C, 1'b0, 0, 1'b0, "basic");
    run8(8'hFF, 8'h01, 1'b0, 0, 1'b0, "ff_01");
    run8(8'hFF, 8'hFF, 1'b1, 0, 1'b0, "ff_ff_c");
    run8(8'h00, 8'h00, 1'b1, 0, 1'b0, "00_00_c");
    run8(8'h80, 8'h80, 1'b0, 2, 1'b0, "msb_carry");

    // Backpressure with in_valid noise during RUN and DONE
    run8(8'hC3, 8'h7E, 1'b1, 5, 1'b1, "backpressure");

    // Reset three cycles into RUN
    while (!in_ready) tick();
    a = 8'h77; b = 8'h99; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_outputs", 64'({in_ready, out_valid, busy, cout, sum}), 64'd0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("midrst_ready_low", 64'(in_ready), 64'd0);
    tick();
    chk("midrst_ready_up", 64'(in_ready), 64'd1);
    run8(8'h12, 8'h34, 1'b0, 0, 1'b0, "after_rst");

    // Back-to-back with in_valid and out_ready held high
    qa = '{8'h01, 8'hF0, 8'h9C, 8'h7F};
    qb = '{8'h02, 8'h20, 8'h64, 8'h80};
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc = 0;
      while (!in_ready && cyc < 50) begin tick(); cyc++; end
      t_acc[k] = cycle;
      a = qa[k]; b = qb[k]; cin = 1'b0;
      tick();
      cyc = 0;
      while (!out_valid && cyc < 50) begin tick(); cyc++; end
      chk("b2b_sum", 64'({cout, sum}), 64'({1'b0, qa[k]} + {1'b0, qb[k]}));
      if (k > 0) chk("b2b_period", 64'(t_acc[k] - t_acc[k-1]), 64'(W + 2));
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Randomized regression at both widths
    for (int i = 0; i < 1000; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)), "rand8");

    run32(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, "w32_wrap");
    run32(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1, "w32_max");
    for (int i = 0; i < 300; i++)
      run32($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3), "rand32");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
